// File: rtl/system_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : system_bus_arbiter
//  Description : Two-port arbiter in front of the system_bus master port.
//                Port 0 is load/store, port 1 is instruction fetch. Accepted
//                reads are tagged in an in-order FIFO so each returning read
//                beat is steered to the port that issued it.
//                Optional feature macro: SYSTEM_BUS_ARBITER_ROUND_ROBIN_EN
//                (defined: round-robin on contention; undefined: port 0 wins).
//  Revision    : 1.0 - initial release
// ============================================================================
module system_bus_arbiter #(
    parameter int MAX_OUTSTANDING_READS = 4
) (
    input  logic        clk,
    input  logic        reset_n,

    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_write_data,
    input  logic [3:0]  m0_byte_enable,
    input  logic        m0_write_req,
    input  logic        m0_read_req,
    output logic [31:0] m0_read_data,
    output logic        m0_read_data_valid,

    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_write_data,
    input  logic [3:0]  m1_byte_enable,
    input  logic        m1_write_req,
    input  logic        m1_read_req,
    output logic [31:0] m1_read_data,
    output logic        m1_read_data_valid,

    input  logic        bus_ready,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_write_data,
    output logic [3:0]  bus_byte_enable,
    output logic        bus_write_req,
    output logic        bus_read_req,
    input  logic [31:0] bus_read_data,
    input  logic        bus_read_data_valid
);

    localparam int                  c_ptr_w      = $clog2(MAX_OUTSTANDING_READS);
    localparam int                  c_cnt_w      = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0]  c_full_count = c_cnt_w'(MAX_OUTSTANDING_READS);
    localparam logic [c_ptr_w-1:0]  c_ptr_one    = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one    = c_cnt_w'(1);

`ifdef SYSTEM_BUS_ARBITER_ROUND_ROBIN_EN
    localparam logic c_rr_en = 1'b1;
`else
    localparam logic c_rr_en = 1'b0;
`endif

    // Read-tag FIFO state and arbitration history
    logic               r_tags [0:MAX_OUTSTANDING_READS-1];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_last_grant;

    logic w_req0;
    logic w_req1;
    logic w_grant0;
    logic w_grant1;
    logic w_empty;
    logic w_full;
    logic w_blocked;
    logic w_sel_read;
    logic w_sel_write;
    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_head_tag;

    assign w_req0 = m0_read_req | m0_write_req;
    assign w_req1 = m1_read_req | m1_write_req;

    // Port 1 wins when alone, or on contention when round-robin says it is
    // its turn. Otherwise port 0 holds the grant (and the idle bus fields).
    assign w_grant1 = w_req1 && (!w_req0 || (c_rr_en && (r_last_grant == 1'b0)));
    assign w_grant0 = w_req0 && !w_grant1;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_full_count);
    // A response beat in the same cycle frees the slot a new read needs.
    assign w_blocked = w_full && !bus_read_data_valid;

    assign w_sel_read  = w_grant1 ? m1_read_req  : m0_read_req;
    assign w_sel_write = w_grant1 ? m1_write_req : m0_write_req;

    assign bus_addr        = w_grant1 ? m1_addr        : m0_addr;
    assign bus_write_data  = w_grant1 ? m1_write_data  : m0_write_data;
    assign bus_byte_enable = w_grant1 ? m1_byte_enable : m0_byte_enable;
    assign bus_read_req    = reset_n && w_sel_read && !w_blocked;
    assign bus_write_req   = reset_n && w_sel_write;

    // A blocked read stalls its own port; the other port is not substituted.
    assign m0_ready = reset_n && w_grant0 && bus_ready && !(m0_read_req && w_blocked);
    assign m1_ready = reset_n && w_grant1 && bus_ready && !(m1_read_req && w_blocked);

    // Ready already implies grant and request, so it marks acceptance.
    assign w_accept = m0_ready || m1_ready;
    assign w_push   = (m0_ready && m0_read_req) || (m1_ready && m1_read_req);
    assign w_pop    = reset_n && bus_read_data_valid && !w_empty;

    assign w_head_tag = r_tags[r_rd_ptr];

    assign m0_read_data       = bus_read_data;
    assign m1_read_data       = bus_read_data;
    assign m0_read_data_valid = w_pop && (w_head_tag == 1'b0);
    assign m1_read_data_valid = w_pop && (w_head_tag == 1'b1);

    // Pointer, occupancy and last-grant bookkeeping
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_last_grant <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
            if (w_accept) begin
                r_last_grant <= m1_ready;
            end
        end
    end

    // Tag storage needs no reset: entries are only read while valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tags[r_wr_ptr] <= m1_ready;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_system_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_system_bus_arbiter
//  Description : Directed scoreboard bench for system_bus_arbiter. Stimulus
//                pushes expected read responses; a negedge monitor pops them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_system_bus_arbiter;

    logic        clk;
    logic        reset_n;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_addr, m1_addr;
    logic [31:0] m0_write_data, m1_write_data;
    logic [3:0]  m0_byte_enable, m1_byte_enable;
    logic        m0_write_req, m1_write_req;
    logic        m0_read_req, m1_read_req;
    logic [31:0] m0_read_data, m1_read_data;
    logic        m0_read_data_valid, m1_read_data_valid;
    logic        bus_ready;
    logic [31:0] bus_addr;
    logic [31:0] bus_write_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_write_req;
    logic        bus_read_req;
    logic [31:0] bus_read_data;
    logic        bus_read_data_valid;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    system_bus_arbiter #(.MAX_OUTSTANDING_READS(4)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .m0_ready            (m0_ready),
        .m0_addr             (m0_addr),
        .m0_write_data       (m0_write_data),
        .m0_byte_enable      (m0_byte_enable),
        .m0_write_req        (m0_write_req),
        .m0_read_req         (m0_read_req),
        .m0_read_data        (m0_read_data),
        .m0_read_data_valid  (m0_read_data_valid),
        .m1_ready            (m1_ready),
        .m1_addr             (m1_addr),
        .m1_write_data       (m1_write_data),
        .m1_byte_enable      (m1_byte_enable),
        .m1_write_req        (m1_write_req),
        .m1_read_req         (m1_read_req),
        .m1_read_data        (m1_read_data),
        .m1_read_data_valid  (m1_read_data_valid),
        .bus_ready           (bus_ready),
        .bus_addr            (bus_addr),
        .bus_write_data      (bus_write_data),
        .bus_byte_enable     (bus_byte_enable),
        .bus_write_req       (bus_write_req),
        .bus_read_req        (bus_read_req),
        .bus_read_data       (bus_read_data),
        .bus_read_data_valid (bus_read_data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Response monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (m0_read_data_valid || m1_read_data_valid) begin
            exp_t        e;
            logic        got_port;
            logic [31:0] got_data;
            n_tests++;
            got_port = m1_read_data_valid;
            got_data = got_port ? m1_read_data : m0_read_data;
            if (m0_read_data_valid && m1_read_data_valid) begin
                n_fail++;
                $display("FAIL both_strobes: got m0 and m1 valid together, required one");
            end else if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: got port %0d data %08h, required no strobe",
                         got_port, got_data);
            end else begin
                e = sb_q.pop_front();
                if (got_port !== e.port || got_data !== e.data) begin
                    n_fail++;
                    $display("FAIL response_route: got port %0d data %08h, required port %0d data %08h",
                             got_port, got_data, e.port, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, required %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        m0_read_req = 1'b0; m0_write_req = 1'b0;
        m1_read_req = 1'b0; m1_write_req = 1'b0;
        bus_read_data_valid = 1'b0;
        bus_read_data = 32'h0;
    endtask

    // Drive one response beat this cycle, expected at the given port
    task automatic resp(input logic port, input logic [31:0] d);
        exp_t e;
        bus_read_data_valid = 1'b1;
        bus_read_data = d;
        e.port = port;
        e.data = d;
        sb_q.push_back(e);
    endtask

    // Drive one response beat this cycle that must be dropped
    task automatic resp_drop(input logic [31:0] d);
        bus_read_data_valid = 1'b1;
        bus_read_data = d;
    endtask

    task automatic check_drained(input string name);
        check(name, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        logic        exp_port;
        logic [31:0] d;
        reset_n = 1'b0;
        bus_ready = 1'b1;
        m0_addr = 32'h0; m1_addr = 32'h0;
        m0_write_data = 32'h0; m1_write_data = 32'h0;
        m0_byte_enable = 4'hF; m1_byte_enable = 4'hF;
        clear();

        // ---- Reset state: requests present but everything held off
        step();
        m0_read_req = 1'b1; m1_write_req = 1'b1;
        #1;
        check("rst_m0_ready", 32'(m0_ready), 32'd0);
        check("rst_m1_ready", 32'(m1_ready), 32'd0);
        check("rst_bus_read_req", 32'(bus_read_req), 32'd0);
        check("rst_bus_write_req", 32'(bus_write_req), 32'd0);
        step();
        clear();
        reset_n = 1'b1;
        step();

        // ---- Single-port reads from port 1, responses two cycles later
        for (int c = 0; c < 5; c++) begin
            clear();
            if (c < 3) begin
                m1_read_req = 1'b1;
                m1_addr = 32'h1000_0000 + 32'(4 * c);
            end
            if (c >= 2) begin
                d = 32'h11 * 32'(c - 1);
                resp(1'b1, d);
            end
            #1;
            if (c < 3) begin
                check("sp_m1_ready", 32'(m1_ready), 32'd1);
                check("sp_bus_addr", bus_addr, 32'h1000_0000 + 32'(4 * c));
                check("sp_bus_read_req", 32'(bus_read_req), 32'd1);
            end
            step();
        end
        clear();
        step();
        check_drained("sp_drained");

        // ---- Contention: both ports read continuously
        m0_addr = 32'h2000_0000; m1_addr = 32'h3000_0000;
        for (int i = 0; i < 4; i++) begin
`ifdef SYSTEM_BUS_ARBITER_ROUND_ROBIN_EN
            exp_port = i[0];
`else
            exp_port = 1'b0;
`endif
            m0_read_req = 1'b1; m1_read_req = 1'b1;
            #1;
            check("ct_m0_ready", 32'(m0_ready), 32'(!exp_port));
            check("ct_m1_ready", 32'(m1_ready), 32'(exp_port));
            check("ct_bus_addr", bus_addr, exp_port ? 32'h3000_0000 : 32'h2000_0000);
            sb_q.push_back('{exp_port, 32'hA0 + 32'(i)});
            step();
        end
        clear();
        // Expected entries were queued in grant order; now drive the data
        for (int i = 0; i < 4; i++) begin
            bus_read_data_valid = 1'b1;
            bus_read_data = 32'hA0 + 32'(i);
            step();
        end
        clear();
        step();
        check_drained("ct_drained");

        // ---- FIFO full: four reads, fifth blocked until a response arrives
        for (int i = 0; i < 4; i++) begin
            m0_read_req = 1'b1;
            m0_addr = 32'h4000_0000 + 32'(4 * i);
            #1;
            check("ff_fill_ready", 32'(m0_ready), 32'd1);
            step();
        end
        m0_addr = 32'h4000_0010;
        #1;
        check("ff_blocked_ready", 32'(m0_ready), 32'd0);
        check("ff_blocked_bus_read_req", 32'(bus_read_req), 32'd0);
        check("ff_blocked_m1_ready", 32'(m1_ready), 32'd0);
        step();
        resp(1'b0, 32'h55);
        #1;
        check("ff_pop_push_ready", 32'(m0_ready), 32'd1);
        check("ff_pop_push_bus_read_req", 32'(bus_read_req), 32'd1);
        step();
        bus_read_data_valid = 1'b0;
        #1;
        check("ff_still_full_ready", 32'(m0_ready), 32'd0);
        clear();
        for (int i = 0; i < 4; i++) begin
            clear();
            resp(1'b0, 32'h60 + 32'(i));
            step();
        end
        clear();
        step();
        check_drained("ff_drained");

        // ---- Interleaved: reads p0,p1,p1,p0 with writes in between
        m0_addr = 32'h5000_0000; m1_addr = 32'h5100_0000;
        m1_write_req = 1'b1; m1_write_data = 32'hCAFE_0001; m1_byte_enable = 4'h3;
        #1;
        check("il_wr_ready", 32'(m1_ready), 32'd1);
        check("il_wr_bus_write_req", 32'(bus_write_req), 32'd1);
        check("il_wr_data", bus_write_data, 32'hCAFE_0001);
        check("il_wr_be", 32'(bus_byte_enable), 32'h3);
        step(); clear();
        m0_read_req = 1'b1; step(); clear();
        m1_read_req = 1'b1; step(); clear();
        m0_write_req = 1'b1; m0_write_data = 32'hBEEF_0002;
        #1;
        check("il_wr0_bus_write_req", 32'(bus_write_req), 32'd1);
        check("il_wr0_bus_read_req", 32'(bus_read_req), 32'd0);
        step(); clear();
        m1_read_req = 1'b1; step(); clear();
        m0_read_req = 1'b1; step(); clear();
        resp(1'b0, 32'hD0); step(); clear();
        resp(1'b1, 32'hD1); step(); clear();
        resp(1'b1, 32'hD2); step(); clear();
        resp(1'b0, 32'hD3); step(); clear();
        step();
        check_drained("il_drained");

        // ---- Back-pressure: nothing accepted while bus_ready is low
        bus_ready = 1'b0;
        m0_read_req = 1'b1; m1_read_req = 1'b1;
        m0_addr = 32'h6000_0000; m1_addr = 32'h6100_0000;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_m0_ready", 32'(m0_ready), 32'd0);
            check("bp_m1_ready", 32'(m1_ready), 32'd0);
            step();
        end
        bus_ready = 1'b1;
`ifdef SYSTEM_BUS_ARBITER_ROUND_ROBIN_EN
        exp_port = 1'b1;
`else
        exp_port = 1'b0;
`endif
        #1;
        check("bp_resume_m0_ready", 32'(m0_ready), 32'(!exp_port));
        check("bp_resume_m1_ready", 32'(m1_ready), 32'(exp_port));
        step();
        clear();
        resp(exp_port, 32'hE0);
        step();
        clear();
        // Only one read went out; a further beat must be dropped
        resp_drop(32'hE1);
        step();
        clear();
        step();
        check_drained("bp_drained");

        // ---- Reset with three reads outstanding
        m1_addr = 32'h7000_0000;
        for (int i = 0; i < 3; i++) begin
            m1_read_req = 1'b1;
            step();
        end
        reset_n = 1'b0;
        #1;
        check("mr_rst_m1_ready", 32'(m1_ready), 32'd0);
        check("mr_rst_bus_read_req", 32'(bus_read_req), 32'd0);
        step();
        clear();
        reset_n = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            resp_drop(32'hF0 + 32'(i));
            step();
        end
        clear();
        m0_read_req = 1'b1; m0_addr = 32'h7100_0000;
        #1;
        check("mr_new_ready", 32'(m0_ready), 32'd1);
        step();
        clear();
        resp(1'b0, 32'h77);
        step();
        clear();
        step();
        step();
        check_drained("final_drained");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/system_bus_arbiter.md
# system_bus_arbiter

Two-requester arbiter placed in front of the `system_bus` master port, sharing the single 32-bit bus between the data/load-store port (port 0) and the instruction-fetch port (port 1). It forwards each accepted request unchanged onto the bus and tags every accepted read. The tags are held in an in-order tag FIFO, so each returning `read_data_valid` beat is steered back to the requester that issued it. The bus returns reads in issue order with variable latency, including DDR3 back-pressure through `bus_ready`.

## Interface
- `MAX_OUTSTANDING_READS`, default 4: depth of the read-tag FIFO; must be a power of two, minimum 2.
- `clk`  in  1  clock
- `reset_n`  in  1  reset, synchronous, active-low
- `m0_ready` / `m1_ready`  out  1  request accepted this cycle if the port's req is high
- `m0_addr` / `m1_addr`  in  32  request address
- `m0_write_data` / `m1_write_data`  in  32  write data
- `m0_byte_enable` / `m1_byte_enable`  in  4  byte lane enables
- `m0_write_req` / `m1_write_req`  in  1  write request
- `m0_read_req` / `m1_read_req`  in  1  read request
- `m0_read_data` / `m1_read_data`  out  32  read response data
- `m0_read_data_valid` / `m1_read_data_valid`  out  1  read response strobe
- `bus_ready`  in  1  system bus ready
- `bus_addr`  out  32  address to the system bus
- `bus_write_data`  out  32  write data to the system bus
- `bus_byte_enable`  out  4  byte enables to the system bus
- `bus_write_req`  out  1  write request to the system bus
- `bus_read_req`  out  1  read request to the system bus
- `bus_read_data`  in  32  read data from the system bus
- `bus_read_data_valid`  in  1  read response strobe from the system bus

## Operation

**Port requests**
- A port is *requesting* when its `read_req` or `write_req` is high.
- A port never asserts `read_req` and `write_req` together; that case is illegal and the behaviour is unspecified.

**Grant**
- Grant is combinational.
- With one requester, that port is granted.
- With two requesters, priority follows the Configuration section.

**Forwarding**
- The granted port's `addr`, `write_data`, `byte_enable`, `write_req` and `read_req` drive the `bus_*` outputs.
- With no requester, `bus_write_req` = `bus_read_req` = 0 and the `bus_*` data fields carry port 0's values.

**Blocking**
- A read is *blocked* when the tag FIFO holds `MAX_OUTSTANDING_READS` entries.
- A blocked granted read forces `bus_read_req` = 0 and drives the port's ready to 0.
- When a read is blocked, the other port is not granted in its place. This keeps ordering deterministic.

**Ready and acceptance**
- `mN_ready` = granted(N) && `bus_ready` && !(`mN_read_req` && full).
- The ungranted port's ready = 0.
- A transfer is *accepted* when the granted port's req and ready are both high on a clock edge.

**Tag FIFO**
- Each accepted read pushes the port index (0/1).
- Each `bus_read_data_valid` pops the head entry.
- Push and pop in the same cycle leave the count unchanged and are legal when full, since the pop frees the slot the push uses.
- The pointers wrap modulo `MAX_OUTSTANDING_READS`. The count is `$clog2(MAX_OUTSTANDING_READS)+1` bits wide.

**Response routing**
- `bus_read_data` fans out to both `mN_read_data`.
- `mN_read_data_valid` = `bus_read_data_valid` && head tag == N && FIFO non-empty.
- A `bus_read_data_valid` arriving while the FIFO is empty is dropped: no pop and no strobe.
- Writes push nothing and produce no response.

## Timing

**Latency**
- Zero added latency: request path and response path are both combinational through the arbiter.
- A single port can issue back-to-back transfers every cycle while `bus_ready` is high and the FIFO is not full.

**Reset state** (while `reset_n` is low on a clock edge)
- FIFO empty, pointers 0, count 0, `last_grant` = 1.
- While `reset_n` is low:
  - `bus_read_req`, `bus_write_req`, `m0_ready`, `m1_ready` are forced to 0.
  - `mN_read_data_valid` = 0, since the FIFO is empty.

**Reset mid-operation**
- Reset mid-operation discards all outstanding tags.
- Responses still in flight after reset are dropped, by the empty-FIFO rule.

**`last_grant` register**
- Updates only on an accepted transfer, to the accepted port's index.
- Unchanged when `bus_ready` = 0 or when a read is blocked.

## Configuration
- `SYSTEM_BUS_ARBITER_ROUND_ROBIN_EN` defined: with both ports requesting, the port not equal to `last_grant` wins. Alternation is strict on each accepted transfer.
- Not defined: fixed priority, port 0 always wins. `last_grant` is still maintained but does not affect the grant.

## Test plan
- **Single-port reads.** Port 1 issues 3 reads, at A=0x10000000/04/08, with the bus returning 0x11, 0x22, 0x33 two cycles later each. Required: `m1_read_data_valid` strobes ×3 with data 0x11, 0x22, 0x33; `m0_read_data_valid` never high.
- **Contention.** Both ports request reads continuously and `bus_ready` = 1.
  - RR build: grants alternate 0, 1, 0, 1.
  - Fixed build: port 0 wins every cycle and `m1_ready` stays 0.
- **FIFO full.** With `MAX_OUTSTANDING_READS` = 4, issue 4 reads with no responses. Required:
  - the 5th read sees `m0_ready` = 0 and `bus_read_req` = 0;
  - a response in that same cycle allows the 5th read to be accepted, with the count staying at 4.
- **Interleaved responses.** Reads are accepted in the order p0, p1, p1, p0, then 4 responses D0–D3. Required: D0→m0, D1→m1, D2→m1, D3→m0; writes interleaved among them produce no strobes.
- **Back-pressure.** `bus_ready` = 0 for 5 cycles with both ports requesting. Required: no acceptance, no FIFO push, `last_grant` unchanged; transfer proceeds on the cycle `bus_ready` returns to 1.
- **Reset mid-operation.** `reset_n` goes low with 3 reads outstanding, then releases. Required:
  - the FIFO is empty after release;
  - the next 3 late `bus_read_data_valid` beats produce no `mN_read_data_valid`;
  - a new read then routes correctly.
